// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Shared constants and helpers for the probe display block.
//   - SEG_BLANK   : all segments off (active-low encoding).
//   - GLYPH_TABLE : 16 hex glyphs, segment order {g,f,e,d,c,b,a}, active-low.
//   - hex_to_seg  : nibble -> glyph lookup.
// -----------------------------------------------------------------------------
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry [n] is the glyph for nibble n; b and d use the lower-case shapes
    // so they cannot be confused with 8 and 0.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return GLYPH_TABLE[nib];
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Turns a raw, clock-asynchronous pushbutton into a single-cycle pulse on
//   each debounced press.
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous active-high reset
//     button in  raw pushbutton level
//     step   out one-cycle pulse, registered, on each debounced rising edge
//   Latency from a clean press to step high: 2 (sync) + DEBOUNCE + 1 edges.
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic step
);

    localparam int CW = $clog2(DEBOUNCE);

    logic          sync_a;
    logic          sync_b;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] count;
    logic          step_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level_q <= 1'b0;
            level_d <= 1'b0;
            count   <= '0;
            step_q  <= 1'b0;
        end else begin
            sync_a <= button;
            sync_b <= sync_a;
            // The counter only runs while the synchronised input disagrees
            // with the debounced level; any return to agreement restarts it,
            // so a glitch shorter than DEBOUNCE samples never flips level_q.
            if (sync_b == level_q) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE - 1)) begin
                level_q <= sync_b;
                count   <= '0;
            end else begin
                count <= count + 1'b1;
            end
            level_d <= level_q;
            step_q  <= level_q & ~level_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/probe_display_ctrl.sv
// -----------------------------------------------------------------------------
// probe_display_ctrl
//   Debug observation block: selects one of CHANNELS probe buses with a
//   debounced stepper button, captures it under freeze/sample control and
//   shows it on DIGITS seven-segment digits, both in parallel and scanned.
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   asynchronous active-high reset
//     probe_data in   CHANNELS*WIDTH, channel c at [c*WIDTH +: WIDTH]
//     chan_step  in   raw pushbutton, asynchronous to clk
//     freeze     in   high holds the captured value
//     sample_en  in   capture strobe
//     blank_lz   in   enables leading-zero blanking
//     chan_sel   out  current channel
//     captured   out  held probe value
//     hex_par    out  digit i at [i*7 +: 7], {g,f,e,d,c,b,a}, active-low
//     scan_seg   out  segments of the currently scanned digit, active-low
//     scan_an    out  one-hot active-low digit enables
// -----------------------------------------------------------------------------
module probe_display_ctrl
    import display_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 16,
    localparam int CSW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] probe_data,
    input  logic                      chan_step,
    input  logic                      freeze,
    input  logic                      sample_en,
    input  logic                      blank_lz,
    output logic [CSW-1:0]            chan_sel,
    output logic [WIDTH-1:0]          captured,
    output logic [DIGITS*7-1:0]       hex_par,
    output logic [6:0]                scan_seg,
    output logic [DIGITS-1:0]         scan_an
);

    // Padded width covers every digit even when WIDTH is not a multiple of 4
    // or is narrower than the display.
    localparam int PW   = (DIGITS * 4 > WIDTH) ? DIGITS * 4 : WIDTH;
    // Digits at or above LIVE carry no probe bits and are always blank.
    localparam int LIVE = (WIDTH + 3) / 4;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW   = $clog2(SCAN_DIV);

    logic                step_pulse;
    logic [WIDTH-1:0]    sel_data;
    logic [PW-1:0]       padded;
    logic                upper_zero;
    logic [DIGITS*7-1:0] hex_next;
    logic [DW-1:0]       scan_div;
    logic [IW-1:0]       scan_idx;
    logic [6:0]          seg_pick;

    button_debouncer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .button (chan_step),
        .step   (step_pulse)
    );

    // Channel stepper; explicit wrap keeps non-power-of-2 counts in range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_sel <= '0;
        end else if (step_pulse) begin
            chan_sel <= (chan_sel == CSW'(CHANNELS - 1)) ? '0 : chan_sel + 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_sel == CSW'(c)) begin
                sel_data = probe_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // Capture uses the channel selected before this edge, so a step and a
    // sample in the same cycle still capture the old channel once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            captured <= '0;
        end else if (sample_en && !freeze) begin
            captured <= sel_data;
        end
    end

    assign padded = PW'(captured);

    // Walk from the most significant digit down, tracking whether every
    // nibble seen so far (this one included) is zero.
    always_comb begin
        hex_next   = '1;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (padded[i*4 +: 4] == 4'h0);
            if (i >= LIVE || (i != 0 && blank_lz && upper_zero)) begin
                hex_next[i*7 +: 7] = SEG_BLANK;
            end else begin
                hex_next[i*7 +: 7] = hex_to_seg(padded[i*4 +: 4]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_par <= '1;
        end else begin
            hex_par <= hex_next;
        end
    end

    always_comb begin
        seg_pick = SEG_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                seg_pick = hex_par[i*7 +: 7];
            end
        end
    end

    // scan_an/scan_seg are registered copies of the current index, so each
    // digit is driven for exactly SCAN_DIV cycles, starting one edge after
    // reset release with digit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_div <= '0;
            scan_idx <= '0;
            scan_an  <= '1;
            scan_seg <= SEG_BLANK;
        end else begin
            scan_an  <= ~(DIGITS'(1) << scan_idx);
            scan_seg <= seg_pick;
            if (scan_div == DW'(SCAN_DIV - 1)) begin
                scan_div <= '0;
                scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_div <= scan_div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_probe_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_probe_display_ctrl
//   Self-checking bench for probe_display_ctrl with a cycle-level reference
//   model (arithmetic scan position, run-length button model, shift-based
//   blanking rule) compared against every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_probe_display_ctrl;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 4;
    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 16;
    localparam int CSW      = $clog2(CHANNELS);

    // ---------------- clock / reset / DUT ----------------
    logic                      clk = 1'b0;
    logic                      reset;
    logic [CHANNELS*WIDTH-1:0] probe_data;
    logic                      chan_step;
    logic                      freeze;
    logic                      sample_en;
    logic                      blank_lz;
    logic [CSW-1:0]            chan_sel;
    logic [WIDTH-1:0]          captured;
    logic [DIGITS*7-1:0]       hex_par;
    logic [6:0]                scan_seg;
    logic [DIGITS-1:0]         scan_an;

    logic [WIDTH-1:0] ch [CHANNELS];

    always #5 clk = ~clk;

    assign probe_data = {ch[3], ch[2], ch[1], ch[0]};

    probe_display_ctrl #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .probe_data (probe_data),
        .chan_step  (chan_step),
        .freeze     (freeze),
        .sample_en  (sample_en),
        .blank_lz   (blank_lz),
        .chan_sel   (chan_sel),
        .captured   (captured),
        .hex_par    (hex_par),
        .scan_seg   (scan_seg),
        .scan_an    (scan_an)
    );

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;

    int          m_chan;
    logic [31:0] m_cap;
    logic [55:0] m_hex;
    logic [6:0]  m_seg;
    logic [7:0]  m_an;
    int          n_edges;
    bit          db_level;
    bit          last_raw;
    int          run_len;
    logic [31:0] exp_q[$];   // edge numbers at which chan_sel must advance

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [55:0] model_hex(input logic [31:0] v, input bit blz);
        logic [55:0] r;
        logic [3:0]  nib;
        bit          blank;
        r = '1;
        for (int i = 0; i < DIGITS; i++) begin
            nib   = 4'((v >> (4 * i)) & 32'hF);
            blank = (4 * i >= WIDTH) || (i > 0 && blz && ((v >> (4 * i)) == 32'h0));
            r[i*7 +: 7] = blank ? 7'h7F : glyph(nib);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_chan   = 0;
        m_cap    = '0;
        m_hex    = '1;
        m_seg    = 7'h7F;
        m_an     = 8'hFF;
        n_edges  = 0;
        db_level = 1'b0;
        last_raw = 1'b0;
        run_len  = 0;
        exp_q.delete();
    endtask

    // Called at each rising edge with the inputs the DUT sees at that edge.
    task automatic model_edge();
        int d;
        if (reset) begin
            model_reset();
            return;
        end
        d     = (n_edges / SCAN_DIV) % DIGITS;
        m_seg = m_hex[d*7 +: 7];
        m_an  = ~(8'd1 << d);
        m_hex = model_hex(m_cap, blank_lz);
        if (sample_en && !freeze) m_cap = ch[m_chan];
        n_edges++;
        // Button: a level counts once it has been sampled DEBOUNCE times in a
        // row; the channel then moves 4 edges later (sync tail, edge, step).
        if (chan_step == last_raw) begin
            run_len++;
        end else begin
            run_len  = 1;
            last_raw = chan_step;
        end
        if (run_len >= DEBOUNCE && chan_step != db_level) begin
            db_level = chan_step;
            if (db_level) exp_q.push_back(32'(n_edges + 4));
        end
        if (exp_q.size() > 0 && exp_q[0] == 32'(n_edges)) begin
            void'(exp_q.pop_front());
            m_chan = (m_chan + 1) % CHANNELS;
        end
    endtask

    task automatic check_all();
        check("chan_sel", 64'(chan_sel), 64'(m_chan));
        check("captured", 64'(captured), 64'(m_cap));
        check("hex_par",  64'(hex_par),  64'(m_hex));
        check("scan_an",  64'(scan_an),  64'(m_an));
        check("scan_seg", 64'(scan_seg), 64'(m_seg));
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int btn_left;
        int gap_left;

        reset     = 1'b1;
        chan_step = 1'b0;
        freeze    = 1'b0;
        sample_en = 1'b0;
        blank_lz  = 1'b0;
        for (int c = 0; c < CHANNELS; c++) ch[c] = '0;
        model_reset();
        #2;
        check_all();
        tick();
        tick();
        reset = 1'b0;

        // Plain decode, no blanking.
        ch[0]     = 32'h1234_ABCD;
        sample_en = 1'b1;
        tick();
        tick();
        check("digit0_d", 64'(hex_par[6:0]),   64'(7'b0100001));
        check("digit7_1", 64'(hex_par[55:49]), 64'(7'b1111001));

        // Leading-zero blanking.
        ch[0]    = 32'h0000_00A5;
        blank_lz = 1'b1;
        tick();
        tick();
        check("lz_upper",  64'(hex_par[55:14]), 64'({6{7'b1111111}}));
        check("lz_digit1", 64'(hex_par[13:7]),  64'(7'b0001000));
        check("lz_digit0", 64'(hex_par[6:0]),   64'(7'b0010010));
        ch[0] = 32'h0;
        tick();
        tick();
        check("zero_digit0", 64'(hex_par[6:0]),  64'(7'b1000000));
        check("zero_rest",   64'(hex_par[55:7]), 64'({7{7'b1111111}}));

        // Freeze holds, release resamples.
        ch[0] = 32'h1;
        tick();
        freeze = 1'b1;
        ch[0]  = 32'h2;
        repeat (3) tick();
        check("freeze_hold", 64'(captured), 64'(32'h1));
        freeze = 1'b0;
        tick();
        check("freeze_release", 64'(captured), 64'(32'h2));

        // Steady display across more than a full scan frame.
        ch[0]    = 32'h0BAD_F00D;
        blank_lz = 1'b0;
        tick();
        freeze = 1'b1;
        repeat (40) tick();
        freeze = 1'b0;

        // Channel stepper: exact latency, glitch rejection, wrap.
        for (int c = 0; c < CHANNELS; c++) ch[c] = 32'(c * 32'h1111_1111 + 32'h5);
        chan_step = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 19) check("step_before", 64'(chan_sel), 64'(0));
            if (k == 20) check("step_at_20",  64'(chan_sel), 64'(1));
        end
        chan_step = 1'b0;
        repeat (25) tick();
        chan_step = 1'b1;
        repeat (10) tick();
        chan_step = 1'b0;
        repeat (30) tick();
        check("glitch_ignored", 64'(chan_sel), 64'(1));
        for (int p = 0; p < 3; p++) begin
            chan_step = 1'b1;
            repeat (20) tick();
            chan_step = 1'b0;
            repeat (25) tick();
        end
        check("chan_wrap", 64'(chan_sel), 64'(0));

        // Randomised operation.
        btn_left = 0;
        gap_left = 30;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 7) == 0)
                ch[$urandom_range(0, CHANNELS - 1)] = $urandom >> $urandom_range(0, 31);
            sample_en = ($urandom_range(0, 3) != 0);
            freeze    = ($urandom_range(0, 4) == 0);
            blank_lz  = 1'($urandom_range(0, 1));
            if (btn_left > 0) begin
                chan_step = 1'b1;
                btn_left--;
            end else if (gap_left > 0) begin
                chan_step = 1'b0;
                gap_left--;
            end else begin
                btn_left = $urandom_range(4, 30);
                gap_left = $urandom_range(4, 30);
            end
            tick();
        end

        // Reset in the middle of a scan and a press.
        for (int c = 0; c < CHANNELS; c++) ch[c] = 32'hDEAD_BEEF;
        freeze    = 1'b0;
        sample_en = 1'b1;
        blank_lz  = 1'b0;
        chan_step = 1'b0;
        repeat (20) tick();
        chan_step = 1'b1;
        repeat (9) tick();
        check("pre_reset_cap", 64'(captured), 64'(32'hDEAD_BEEF));
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_chan_sel", 64'(chan_sel), 64'(0));
        check("rst_captured", 64'(captured), 64'(0));
        check("rst_hex_par",  64'(hex_par),  64'({DIGITS{7'b1111111}}));
        check("rst_scan_an",  64'(scan_an),  64'(8'hFF));
        check("rst_scan_seg", 64'(scan_seg), 64'(7'h7F));
        chan_step = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("first_scan_an", 64'(scan_an), 64'(8'hFE));
        repeat (40) tick();
        check("no_step_after_reset", 64'(chan_sel), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/probe_display_ctrl.md
# probe_display_ctrl

Parametrised debug-observation block for the processor top: selects one of CHANNELS internal WIDTH-bit probe buses and captures it under freeze/sample control. It drives DIGITS seven-segment digits both in parallel (one 7-bit field per digit) and as a time-multiplexed scan. It replaces the fixed two-way output select and per-digit decoders with a debounced channel stepper, freeze, and leading-zero blanking.

## Interface
- WIDTH, 32: probe bus width; nibbles above WIDTH are zero-padded.
- CHANNELS, 4: number of probe buses, ≥2.
- DIGITS, 8: number of hex digits; digits beyond ceil(WIDTH/4) show blank.
- SCAN_DIV, 1000: clocks per digit in scan output, ≥2.
- DEBOUNCE, 16: stable cycles required on chan_step, ≥2.
- CSW, localparam $clog2(CHANNELS).
- clk  in  1  rising-edge clock.
- reset  in  1  reset is asynchronous and active-high.
- probe_data  in  CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH].
- chan_step  in  1  raw pushbutton, asynchronous to clk.
- freeze  in  1  level; high holds captured value.
- sample_en  in  1  capture strobe (tie high for continuous; retire strobe for per-instruction).
- blank_lz  in  1  level; enables leading-zero blanking.
- chan_sel  out  CSW  current channel.
- captured  out  WIDTH  held probe value.
- hex_par  out  DIGITS*7  digit i at [i*7 +: 7], segments {g,f,e,d,c,b,a}, active-low.
- scan_seg  out  7  segments of currently scanned digit, active-low.
- scan_an  out  DIGITS  digit enables, one-hot active-low.

## Operation
- chan_step: 2-flop synchroniser → debouncer (counter reloads on any change; output toggles after DEBOUNCE equal samples) → rising-edge detect → one-cycle step pulse.
- Step pulse: chan_sel increments; CHANNELS-1 wraps to 0; non-power-of-2 CHANNELS never reaches unused codes.
- Capture: captured <= probe_data[chan_sel] when sample_en && !freeze; else hold.
- freeze and step in same cycle: chan_sel still advances, captured holds; new channel appears on first sample after freeze drops.
- Decode: nibble i of captured → hex glyph (0-F standard, b/d lower-case).
- Blanking: digit i (i≥1) is 7'b1111111 when blank_lz and nibbles i..DIGITS-1 all zero; digit 0 never blanked. Digits with i*4 ≥ WIDTH always blank.
- Scan: divider counts 0..SCAN_DIV-1; at terminal count digit index advances, DIGITS-1 wraps to 0. scan_an = ~(1<<index); scan_seg = hex_par field of index.

## Timing
- Reset (async assert, sync deassert by clk edge): chan_sel 0, captured 0, hex_par all ones, scan_seg all ones, scan_an all ones, divider 0, index 0, debouncer state/counter 0.
- First clk edge after reset release: scan_an = ~1, scan_seg = digit 0.
- Reset mid-debounce or mid-scan: all state discarded; no step emitted.
- Button press to chan_sel change: 2 (sync) + DEBOUNCE + 1 (edge) + 1 cycles.
- sample_en at edge N → captured valid after N → hex_par valid after N+1 (registered decode).
- scan_an/scan_seg registered; each digit active exactly SCAN_DIV cycles; full frame DIGITS*SCAN_DIV cycles.
- Glitch shorter than DEBOUNCE cycles: no step.

## Structure
- Package display_pkg: SEG_BLANK constant, 16-entry glyph constant table, function hex_to_seg(logic [3:0]) → logic [6:0].
- Sub-module button_debouncer (synchroniser + counter + edge pulse, parameter DEBOUNCE); one instance.
- Remainder (channel counter, capture mux, blanking, decode registers, scan divider) in probe_display_ctrl.

## Test plan
- Reset asserted mid-scan with captured = 32'hDEAD_BEEF → same-instant chan_sel 0, captured 0, hex_par all ones, scan_an 8'hFF; after release first edge scan_an 8'hFE.
- ch0 = 32'h1234_ABCD, sample_en=1, blank_lz=0 → two cycles later digit0 7'b0100001 ('d'), digit7 7'b1111001 ('1').
- chan_step held 20 cycles (DEBOUNCE=16) → chan_sel 1 at cycle 20; 10-cycle glitch → no change; four valid presses → wraps to 0.
- freeze=1, change ch0 32'h1→32'h2 → captured stays 1; freeze=0 with sample_en → captured 2 next cycle.
- blank_lz=1, captured 32'h0000_00A5 → digits 2-7 7'b1111111, digit1 7'b0001000 ('A'), digit0 7'b0010010 ('5'); captured 0 → digit0 7'b1000000, rest blank.
- SCAN_DIV=4, DIGITS=8 → scan_an steps FE,FD,…,7F every 4 cycles, back to FE after 32 cycles; scan_seg equals matching hex_par field each cycle.
